hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use bubbles,
// EX-stage redirects and mul/div freezes, plus a stall counter and MDU watchdog.
module hazard_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_ID,
  input  logic [31:0]      instr_EX,
  input  logic             MemRead_EX,
  input  logic             RegWEn_EX,
  input  logic             br_taken_EX,
  input  logic             md_start_EX,
  input  logic             md_done,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             md_go,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             md_timeout
);

  localparam int unsigned TO_W = $clog2(MD_TIMEOUT + 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {
    S_IDLE,
    S_MD_BUSY
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_md_timeout;

  logic [4:0] w_rd_ex;
  logic [4:0] w_rs1_id;
  logic [4:0] w_rs2_id;
  logic [6:0] w_op_id;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_lu;
  logic       w_md_go;
  logic       w_md_wait;
  logic       w_stall;
  logic       w_unused_bits;

  // Register-field decode of the ID and EX instructions
  assign w_rd_ex    = instr_EX[11:7];
  assign w_rs1_id   = instr_ID[19:15];
  assign w_rs2_id   = instr_ID[24:20];
  assign w_op_id    = instr_ID[6:0];
  assign w_uses_rs1 = (w_op_id != OP_LUI) && (w_op_id != OP_AUIPC) && (w_op_id != OP_JAL);
  assign w_uses_rs2 = (w_op_id == OP_REG) || (w_op_id == OP_STORE) || (w_op_id == OP_BRANCH);

  assign w_lu = MemRead_EX && RegWEn_EX && (w_rd_ex != 5'd0) &&
                ((w_uses_rs1 && (w_rs1_id == w_rd_ex)) || (w_uses_rs2 && (w_rs2_id == w_rd_ex)));

  // md_start_EX stays high while frozen, so only the IDLE cycle launches the MDU
  assign w_md_go   = (r_state == S_IDLE) && md_start_EX;
  assign w_md_wait = ((r_state == S_IDLE) && md_start_EX && !md_done) ||
                     ((r_state == S_MD_BUSY) && !md_done);
  assign w_stall   = w_md_wait || (w_lu && !br_taken_EX);

  assign w_unused_bits = &{1'b0, instr_ID[31:25], instr_ID[14:7], instr_EX[31:12], instr_EX[6:0]};

  // Pipeline control, highest priority first
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_go        = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      md_go = w_md_go;
      if (w_md_wait) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
      end else if (br_taken_EX) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_lu) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // MDU FSM, watchdog and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_stall_cnt  <= '0;
      r_to_cnt     <= '0;
      r_md_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (md_start_EX && !md_done) begin
            r_state  <= S_MD_BUSY;
            r_to_cnt <= '0;
          end
        end
        S_MD_BUSY: begin
          if (md_done) r_state <= S_IDLE;
          if (r_to_cnt != TO_W'(MD_TIMEOUT)) r_to_cnt <= r_to_cnt + TO_W'(1);
          if (r_to_cnt == TO_W'(MD_TIMEOUT - 1)) r_md_timeout <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign md_timeout = r_md_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues the expected control
// word per cycle and a negedge monitor pops and compares it against the DUT.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned MD_TO = 64;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] LW_X5    = 32'h0000_A283;
  localparam logic [31:0] LW_X0    = 32'h0000_A003;
  localparam logic [31:0] ADD_RS1  = 32'h0022_8333;
  localparam logic [31:0] ADD_X0   = 32'h0020_0333;
  localparam logic [31:0] ADD_RS2  = 32'h0051_0333;
  localparam logic [31:0] LUI_X6   = 32'h0000_1337;
  localparam logic [31:0] MUL_X7   = 32'h0262_83B3;

  // pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, md_go
  localparam logic [6:0] C_NORM  = 7'b111_000_0;
  localparam logic [6:0] C_LU    = 7'b001_010_0;
  localparam logic [6:0] C_BR    = 7'b111_110_0;
  localparam logic [6:0] C_MDW   = 7'b000_001_0;
  localparam logic [6:0] C_MDGO  = 7'b000_001_1;
  localparam logic [6:0] C_GOFST = 7'b111_000_1;
  localparam logic [6:0] C_RST   = 7'b111_111_0;

  typedef struct {
    string      name;
    logic [6:0] ctl;
    logic [3:0] cnt;
    logic       to;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instr_ID, instr_EX;
  logic             MemRead_EX, RegWEn_EX, br_taken_EX, md_start_EX, md_done;
  logic             pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, md_go;
  logic [CNT_W-1:0] stall_cnt;
  logic             md_timeout;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .MD_TIMEOUT(MD_TO)) dut (
    .clk(clk), .rst(rst), .instr_ID(instr_ID), .instr_EX(instr_EX),
    .MemRead_EX(MemRead_EX), .RegWEn_EX(RegWEn_EX), .br_taken_EX(br_taken_EX),
    .md_start_EX(md_start_EX), .md_done(md_done),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .md_go(md_go), .stall_cnt(stall_cnt), .md_timeout(md_timeout)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs just after the edge and queue its expected response
  task automatic step(input string nm, input logic r, input logic [31:0] id, input logic [31:0] ex,
                      input logic mr, input logic rw, input logic br, input logic ms, input logic md,
                      input logic [6:0] ectl, input int ecnt, input logic eto);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; instr_ID = id; instr_EX = ex; MemRead_EX = mr; RegWEn_EX = rw;
    br_taken_EX = br; md_start_EX = ms; md_done = md;
    e.name = nm; e.ctl = ectl; e.cnt = 4'(ecnt); e.to = eto;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] ctl;
      e = q.pop_front();
      ctl = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, md_go};
      checks = checks + 3;
      if (ctl !== e.ctl) begin
        errors = errors + 1;
        $display("FAIL %s ctl: got %b want %b", e.name, ctl, e.ctl);
      end
      if (stall_cnt !== e.cnt) begin
        errors = errors + 1;
        $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.cnt);
      end
      if (md_timeout !== e.to) begin
        errors = errors + 1;
        $display("FAIL %s md_timeout: got %b want %b", e.name, md_timeout, e.to);
      end
    end
  end

  initial begin
    rst = 1'b1; instr_ID = NOP; instr_EX = NOP; MemRead_EX = 1'b0; RegWEn_EX = 1'b0;
    br_taken_EX = 1'b0; md_start_EX = 1'b0; md_done = 1'b0;
    repeat (2) @(posedge clk);

    step("reset",        1, NOP,     NOP,    0, 0, 0, 0, 0, C_RST,  0, 0);
    step("lu_rs1",       0, ADD_RS1, LW_X5,  1, 1, 0, 0, 0, C_LU,   0, 0);
    step("lu_bubble",    0, ADD_RS1, NOP,    0, 0, 0, 0, 0, C_NORM, 1, 0);
    step("lw_x0",        0, ADD_X0,  LW_X0,  1, 1, 0, 0, 0, C_NORM, 1, 0);
    step("lw_lui",       0, LUI_X6,  LW_X5,  1, 1, 0, 0, 0, C_NORM, 1, 0);
    step("lu_rs2",       0, ADD_RS2, LW_X5,  1, 1, 0, 0, 0, C_LU,   1, 0);
    step("rs2_bubble",   0, ADD_RS2, NOP,    0, 0, 0, 0, 0, C_NORM, 2, 0);
    step("lw_no_wen",    0, ADD_RS1, LW_X5,  1, 0, 0, 0, 0, C_NORM, 2, 0);
    step("br_over_lu",   0, ADD_RS1, LW_X5,  1, 1, 1, 0, 0, C_BR,   2, 0);
    step("after_br",     0, NOP,     NOP,    0, 0, 0, 0, 0, C_NORM, 2, 0);

    step("md_start",     0, NOP, MUL_X7, 0, 1, 0, 1, 0, C_MDGO, 2, 0);
    for (int k = 1; k < 5; k++)
      step("md_wait",    0, NOP, MUL_X7, 0, 1, 0, 1, 0, C_MDW, 2 + k, 0);
    step("md_done",      0, NOP, MUL_X7, 0, 1, 0, 1, 1, C_NORM, 7, 0);
    step("md_after",     0, NOP, NOP,    0, 0, 0, 0, 0, C_NORM, 7, 0);
    step("md_fast",      0, NOP, MUL_X7, 0, 1, 0, 1, 1, C_GOFST, 7, 0);
    step("md_fast_next", 0, NOP, NOP,    0, 0, 0, 0, 0, C_NORM, 7, 0);

    step("reset_to",     1, NOP, NOP,    0, 0, 0, 0, 0, C_RST,  7, 0);
    step("to_start",     0, NOP, MUL_X7, 0, 1, 0, 1, 0, C_MDGO, 0, 0);
    for (int k = 1; k <= 70; k++)
      step("to_busy",    0, NOP, MUL_X7, 0, 1, 0, 1, 0, C_MDW, (k > 15) ? 15 : k, (k >= 65) ? 1'b1 : 1'b0);
    step("rst_in_busy",  1, NOP, MUL_X7, 0, 1, 0, 1, 0, C_RST,  15, 1);
    step("post_rst",     0, NOP, NOP,    0, 0, 0, 0, 0, C_NORM, 0, 0);
    step("restart_go",   0, NOP, MUL_X7, 0, 1, 0, 1, 0, C_MDGO, 0, 0);
    step("restart_done", 0, NOP, MUL_X7, 0, 1, 0, 1, 1, C_NORM, 1, 0);
    step("restart_idle", 0, NOP, NOP,    0, 0, 0, 0, 0, C_NORM, 1, 0);

    step("reset_sat",    1, NOP, NOP,    0, 0, 0, 0, 0, C_RST,  1, 0);
    for (int i = 0; i < 20; i++)
      step("sat_lu",     0, ADD_RS1, LW_X5, 1, 1, 0, 0, 0, C_LU, (i > 15) ? 15 : i, 0);
    step("sat_hold",     0, NOP, NOP,    0, 0, 0, 0, 0, C_NORM, 15, 0);

    for (int w = 0; w < 5 && q.size() > 0; w++) @(posedge clk);
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
